nap_countdown_ctrl: RTL

- Sequences the nap timer once the keypad selector has finished setting.
- Captures the BCD setting (minutes, tens of seconds, seconds) and counts down at one step per 1 Hz strobe.
- Supports pause/resume and cancel, then raises a timed alarm at 0:00.
- Sits between the keypad selector and the display/buzzer drivers.

---
 rtl/nap_countdown_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/nap_countdown_ctrl.sv
// Nap timer sequencer: captures a clamped BCD setting, counts it down on the 1 Hz strobe,
// handles pause/resume and cancel, and raises a self-timed alarm when the count reaches 0:00.
module nap_countdown_ctrl #(
   parameter int ALARM_SECS = 10
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       tick_1hz,
   input  logic       complete_setting,
   input  logic [3:0] set_min,
   input  logic [3:0] set_ten,
   input  logic [3:0] set_one,
   input  logic       sharp,
   input  logic       star,
   output logic [3:0] cur_min,
   output logic [3:0] cur_ten,
   output logic [3:0] cur_one,
   output logic       running,
   output logic       paused,
   output logic       alarm,
   output logic       done_pulse,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RUN   = 3'd1,
      PAUSE = 3'd2,
      ALARM = 3'd3
   } state_t;

   localparam logic [7:0] ALARM_LIMIT = 8'(ALARM_SECS);

   state_t     state_q, state_d;
   logic [3:0] min_q, ten_q, one_q;
   logic [3:0] min_d, ten_d, one_d;
   logic [3:0] dec_min, dec_ten, dec_one;
   logic [3:0] ld_min, ld_ten, ld_one;
   logic [7:0] acnt_q, acnt_d;
   logic       done_q, done_d;
   logic       cs_q, sharp_q, star_q;
   logic       star_raw, sharp_raw, load_raw;
   logic       star_ev, sharp_ev, load_ev, tick_ev;

   assign star_raw  = star & ~star_q;
   assign sharp_raw = sharp & ~sharp_q;
   assign load_raw  = complete_setting & ~cs_q;

   // Only the highest-priority event of a cycle survives; the rest are dropped, not deferred.
   assign star_ev  = star_raw;
   assign sharp_ev = sharp_raw & ~star_raw;
   assign load_ev  = load_raw & ~star_raw & ~sharp_raw;
   assign tick_ev  = tick_1hz & ~(star_raw | sharp_raw | load_raw);

   assign ld_min = (set_min > 4'd9) ? 4'd9 : set_min;
   assign ld_ten = (set_ten > 4'd5) ? 4'd5 : set_ten;
   assign ld_one = (set_one > 4'd9) ? 4'd9 : set_one;

   // BCD decrement with borrow across the seconds and tens-of-seconds digits.
   always_comb begin
      dec_min = min_q;
      dec_ten = ten_q;
      dec_one = one_q;
      if (one_q != 4'd0) begin
         dec_one = one_q - 4'd1;
      end else begin
         dec_one = 4'd9;
         if (ten_q != 4'd0) begin
            dec_ten = ten_q - 4'd1;
         end else begin
            dec_ten = 4'd5;
            dec_min = min_q - 4'd1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      min_d   = min_q;
      ten_d   = ten_q;
      one_d   = one_q;
      acnt_d  = acnt_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (load_ev) begin
               min_d = ld_min;
               ten_d = ld_ten;
               one_d = ld_one;
               if ({ld_min, ld_ten, ld_one} != 12'd0) state_d = RUN;
            end
         end
         RUN: begin
            if (star_ev) begin
               state_d = IDLE;
               min_d   = 4'd0;
               ten_d   = 4'd0;
               one_d   = 4'd0;
            end else if (sharp_ev) begin
               state_d = PAUSE;
            end else if (tick_ev && ({min_q, ten_q, one_q} != 12'd0)) begin
               min_d = dec_min;
               ten_d = dec_ten;
               one_d = dec_one;
               if ({dec_min, dec_ten, dec_one} == 12'd0) begin
                  state_d = ALARM;
                  done_d  = 1'b1;
                  acnt_d  = 8'd0;
               end
            end
         end
         PAUSE: begin
            if (star_ev) begin
               state_d = IDLE;
               min_d   = 4'd0;
               ten_d   = 4'd0;
               one_d   = 4'd0;
            end else if (sharp_ev) begin
               state_d = RUN;
            end
         end
         ALARM: begin
            if (star_ev || sharp_ev) begin
               state_d = IDLE;
            end else if (tick_ev) begin
               acnt_d = acnt_q + 8'd1;
               if (acnt_q + 8'd1 == ALARM_LIMIT) state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            min_d   = 4'd0;
            ten_d   = 4'd0;
            one_d   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         min_q   <= 4'd0;
         ten_q   <= 4'd0;
         one_q   <= 4'd0;
         acnt_q  <= 8'd0;
         done_q  <= 1'b0;
         cs_q    <= 1'b0;
         sharp_q <= 1'b0;
         star_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         min_q   <= min_d;
         ten_q   <= ten_d;
         one_q   <= one_d;
         acnt_q  <= acnt_d;
         done_q  <= done_d;
         cs_q    <= complete_setting;
         sharp_q <= sharp;
         star_q  <= star;
      end
   end

   assign cur_min    = min_q;
   assign cur_ten    = ten_q;
   assign cur_one    = one_q;
   assign running    = (state_q == RUN);
   assign paused     = (state_q == PAUSE);
   assign alarm      = (state_q == ALARM);
   assign done_pulse = done_q;
   assign state      = state_q;

endmodule
